fiao_multi_sel_ctrl: RTL and testbench
======================================

# fiao_multi_sel_ctrl

Self-contained first-in-any-out (FIAO) slot controller for issue/reservation queues. It owns the entry valid bits and the head/tail pointers internally, so no external queue manager is needed. Each cycle it allocates up to EnqWidth slots in order, grants up to SelWidth ready entries (oldest-first when configured), and retires freed holes at the head so slots can be reused. It sits between rename/dispatch (enqueue side) and the wakeup/issue logic (select side).

## Interface
- Depth, 8: slot count; power of two, ≥4.
- EnqWidth, 2: enqueue lanes, 1..Depth.
- SelWidth, 2: select/issue lanes, 1..Depth.
- DeqWidth, 2: maximum head retirements per cycle, 1..Depth.
- PtrWidth (local), $clog2(Depth).

- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enq_vld_i  in  EnqWidth  per-lane allocation request.
- enq_rdy_o  out  EnqWidth  lane i ready when free slots > i and flush_i=0.
- enq_ptr_o  out  EnqWidth×PtrWidth  slot assigned to lane i; meaningful when vld&rdy.
- sel_req_i  in  Depth  per-slot "operands ready" from wakeup.
- sel_vld_o  out  SelWidth  grant lane valid.
- sel_ptr_o  out  SelWidth×PtrWidth  granted slot index.
- sel_mask_o  out  SelWidth×Depth  one-hot granted slot; zero when sel_vld_o=0.
- sel_ack_i  in  SelWidth  issue accepted; clears that slot's valid.
- flush_i  in  1  synchronous kill-all.
- entry_vld_o  out  Depth  registered slot valid bits.
- cnt_o  out  PtrWidth+1  occupied span (tail−head), holes included.
- full_o / empty_o  out  1 each  cnt_o==Depth / cnt_o==0.

## Operation
- State: vld[Depth], head {flag,ptr}, tail {flag,ptr}. Pointers wrap mod Depth and toggle the flag on wrap. cnt = {tail}−{head} with flag arithmetic.
- Enqueue: fire_i = enq_vld_i[i] & enq_rdy_o[i]. Firing lanes are compacted: enq_ptr_o[i] = tail + popcount(fire[i−1:0]). Sparse vld patterns are legal. Tail advances by popcount(fire). The target vld bits are set.
- rdy uses the registered cnt only. There is no bypass of same-cycle retirement.
- Select: candidates = sel_req_i & vld. Grant lane k takes the k-th candidate in priority order. Grants are combinational and disjoint; unused lanes have sel_vld_o=0.
- Ack: sel_ack_i[k] with sel_vld_o[k]=1 clears vld[sel_ptr_o[k]]. Ack on an invalid lane is ignored.
- Retire: starting at head, count consecutive slots with vld=0 inside [head,tail), up to DeqWidth. Head advances by that count. Retire uses registered vld, so it is blind to same-cycle acks.
- Holes beyond the first valid slot are not reusable until head passes them.
- Flush: highest priority. Next state is vld=0, head=tail=0, both flags 0. Enqueue, ack and retire in that cycle are discarded.

## Timing
- Reset values: vld=0, pointers=0, enq_rdy_o=all 1, enq_ptr_o[i]=i, sel_vld_o=0, sel_mask_o=0, cnt_o=0, empty_o=1, full_o=0.
- Enqueue at edge N: entry_vld_o and cnt_o update after N; the slot is selectable from cycle N+1.
- Ack in cycle N: vld clears at edge N. Head may pass the slot at edge N+1, so cnt_o drops in cycle N+2.
- Full: enq_rdy_o=0 until a retire commits, giving 1 cycle rdy latency after retire.
- Simultaneous enqueue and retire: both pointer updates apply in the same edge.
- Selection never grants a slot enqueued in the same cycle.
- Reset asserted mid-operation: immediate return to reset values, no enqueue completes.

## Configuration
- FIAO_AGE_SEL_EN defined: priority rotates from head, giving oldest-first with wrap (head, head+1, …, head−1).
- FIAO_AGE_SEL_EN undefined: fixed lowest-index-first priority with no rotator. Cheaper, but not age-ordered.
- Enqueue and retire behaviour is identical in both builds.

## Test plan
Depth=8, EnqWidth=SelWidth=DeqWidth=2.
- Reset: rstn 0→1 → empty_o=1, cnt_o=0, enq_rdy_o=2'b11, sel_vld_o=0.
- Fill: enq_vld_i=2'b11 for 4 cycles → enq_ptr_o pairs (0,1),(2,3),(4,5),(6,7). Then full_o=1, cnt_o=8, enq_rdy_o=2'b00. Sparse enq_vld_i=2'b10 on an empty queue → lane1 gets slot 0.
- Holes: slots 0–3 valid; ack slots 1,3 → vld=…0101, cnt_o stays 4. Ack slot 0 → head moves to 2 after two cycles, then cnt_o=2.
- Retire limit: slots 0–3 all acked → head 0→2→4 over two edges, never more than 2 per cycle.
- Wrap and age: head=6, slots 6,7,0,1 valid, sel_req_i=8'hFF. With FIAO_AGE_SEL_EN → sel_ptr_o=(6,7). Without it → (0,1).
- Flush: flush_i=1 with enq_vld_i=2'b11 and sel_ack_i=2'b11 → enq_rdy_o=0 that cycle. Next cycle cnt_o=0, entry_vld_o=0, empty_o=1.

Source files
------------

// File: rtl/fiao_multi_sel_ctrl.sv
// First-in-any-out slot controller: in-order allocation, N-way select, hole retirement at head.
// Define FIAO_AGE_SEL_EN for head-rotated (oldest-first) select priority; default is lowest-index-first.
module fiao_multi_sel_ctrl #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned EnqWidth = 2,
    parameter int unsigned SelWidth = 2,
    parameter int unsigned DeqWidth = 2,
    localparam int unsigned PtrWidth = $clog2(Depth)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [EnqWidth-1:0]          enq_vld_i,
    output logic [EnqWidth-1:0]          enq_rdy_o,
    output logic [EnqWidth*PtrWidth-1:0] enq_ptr_o,
    input  logic [Depth-1:0]             sel_req_i,
    output logic [SelWidth-1:0]          sel_vld_o,
    output logic [SelWidth*PtrWidth-1:0] sel_ptr_o,
    output logic [SelWidth*Depth-1:0]    sel_mask_o,
    input  logic [SelWidth-1:0]          sel_ack_i,
    input  logic                         flush_i,
    output logic [Depth-1:0]             entry_vld_o,
    output logic [PtrWidth:0]            cnt_o,
    output logic                         full_o,
    output logic                         empty_o
);

    logic [Depth-1:0]    vld_q, vld_d;
    logic [PtrWidth:0]   head_q, head_d;
    logic [PtrWidth:0]   tail_q, tail_d;
    logic [PtrWidth:0]   cnt;
    logic [PtrWidth:0]   free_cnt;
    logic [EnqWidth-1:0] fire;
    logic [PtrWidth:0]   nfire;
    logic [PtrWidth:0]   ret_cnt;
    logic                ret_run;
    logic [PtrWidth-1:0] ret_slot;
    logic [Depth-1:0]    rem;
    logic                found;
    logic [PtrWidth-1:0] slot;
    logic [PtrWidth-1:0] pick;

    // {flag,ptr} is a modulo-2*Depth counter, so plain subtraction yields occupancy
    assign cnt         = tail_q - head_q;
    assign free_cnt    = (PtrWidth+1)'(Depth) - cnt;
    assign cnt_o       = cnt;
    assign full_o      = (cnt == (PtrWidth+1)'(Depth));
    assign empty_o     = (cnt == '0);
    assign entry_vld_o = vld_q;

    always_comb begin
        enq_rdy_o = '0;
        enq_ptr_o = '0;
        fire      = '0;
        nfire     = '0;
        for (int unsigned i = 0; i < EnqWidth; i++) begin
            enq_rdy_o[i] = !flush_i && (free_cnt > (PtrWidth+1)'(i));
            fire[i]      = enq_vld_i[i] & enq_rdy_o[i];
            // idle lanes report tail+i so the reset view is 0,1,2,...
            enq_ptr_o[i*PtrWidth +: PtrWidth] = fire[i]
                ? tail_q[PtrWidth-1:0] + nfire[PtrWidth-1:0]
                : tail_q[PtrWidth-1:0] + PtrWidth'(i);
            nfire = nfire + (PtrWidth+1)'(fire[i]);
        end
    end

    always_comb begin
        sel_vld_o  = '0;
        sel_ptr_o  = '0;
        sel_mask_o = '0;
        rem        = sel_req_i & vld_q;
        found      = 1'b0;
        slot       = '0;
        pick       = '0;
        for (int unsigned k = 0; k < SelWidth; k++) begin
            found = 1'b0;
            pick  = '0;
            for (int unsigned j = 0; j < Depth; j++) begin
`ifdef FIAO_AGE_SEL_EN
                slot = head_q[PtrWidth-1:0] + PtrWidth'(j);
`else
                slot = PtrWidth'(j);
`endif
                if (!found && rem[slot]) begin
                    found = 1'b1;
                    pick  = slot;
                end
            end
            if (found) begin
                rem[pick]                         = 1'b0;
                sel_vld_o[k]                      = 1'b1;
                sel_ptr_o[k*PtrWidth +: PtrWidth] = pick;
                sel_mask_o[k*Depth +: Depth]      = Depth'(1) << pick;
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        ret_cnt  = '0;
        ret_run  = 1'b1;
        ret_slot = '0;
        // retirement looks only at registered valids, never at this cycle's acks
        for (int unsigned j = 0; j < DeqWidth; j++) begin
            ret_slot = head_q[PtrWidth-1:0] + PtrWidth'(j);
            if (ret_run && ((PtrWidth+1)'(j) < cnt) && !vld_q[ret_slot]) begin
                ret_cnt = ret_cnt + (PtrWidth+1)'(1);
            end else begin
                ret_run = 1'b0;
            end
        end
        for (int unsigned k = 0; k < SelWidth; k++) begin
            if (sel_ack_i[k] && sel_vld_o[k]) begin
                vld_d[sel_ptr_o[k*PtrWidth +: PtrWidth]] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < EnqWidth; i++) begin
            if (fire[i]) begin
                vld_d[enq_ptr_o[i*PtrWidth +: PtrWidth]] = 1'b1;
            end
        end
        head_d = head_q + ret_cnt;
        tail_d = tail_q + nfire;
        if (flush_i) begin
            vld_d  = '0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_fiao_multi_sel_ctrl.sv
// Self-checking bench for fiao_multi_sel_ctrl: directed scenarios plus randomized traffic against an abstract queue model.
module tb_fiao_multi_sel_ctrl;

    localparam int D  = 8;
    localparam int EW = 2;
    localparam int SW = 2;
    localparam int DW = 2;
    localparam int PW = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic [EW-1:0]  enq_vld_i;
    logic [EW-1:0]  enq_rdy_o;
    logic [EW*PW-1:0] enq_ptr_o;
    logic [D-1:0]   sel_req_i;
    logic [SW-1:0]  sel_vld_o;
    logic [SW*PW-1:0] sel_ptr_o;
    logic [SW*D-1:0]  sel_mask_o;
    logic [SW-1:0]  sel_ack_i;
    logic           flush_i;
    logic [D-1:0]   entry_vld_o;
    logic [PW:0]    cnt_o;
    logic           full_o;
    logic           empty_o;

    int ntests = 0;
    int nfail  = 0;

    // Model: head/tail are free-running occupancy counters mod 2*D
    int m_head;
    int m_tail;
    bit m_vld [D];

    fiao_multi_sel_ctrl #(
        .Depth(D), .EnqWidth(EW), .SelWidth(SW), .DeqWidth(DW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .enq_vld_i(enq_vld_i), .enq_rdy_o(enq_rdy_o), .enq_ptr_o(enq_ptr_o),
        .sel_req_i(sel_req_i), .sel_vld_o(sel_vld_o), .sel_ptr_o(sel_ptr_o),
        .sel_mask_o(sel_mask_o), .sel_ack_i(sel_ack_i), .flush_i(flush_i),
        .entry_vld_o(entry_vld_o), .cnt_o(cnt_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
    endtask

    task automatic set_in(input logic [EW-1:0] ev, input logic [D-1:0] req,
                          input logic [SW-1:0] ack, input logic fl);
        enq_vld_i = ev;
        sel_req_i = req;
        sel_ack_i = ack;
        flush_i   = fl;
    endtask

    // Checks all outputs against the model for the current inputs, then advances one clock.
    task automatic step(input string tag);
        int cnt, nf, r, slot;
        int cand[$];
        bit fire [EW];
        int eptr [EW];
        int gptr [SW];
        bit gv   [SW];
        logic [D-1:0] ev, em;
        bit rdy;
        #1;
        cnt = (m_tail - m_head) & 15;
        for (int i = 0; i < D; i++) ev[i] = m_vld[i];
        check({tag, ".vld"},   64'(entry_vld_o), 64'(ev));
        check({tag, ".cnt"},   64'(cnt_o), 64'(cnt));
        check({tag, ".full"},  64'(full_o), 64'(cnt == D));
        check({tag, ".empty"}, 64'(empty_o), 64'(cnt == 0));
        nf = 0;
        for (int i = 0; i < EW; i++) begin
            rdy = !flush_i && ((D - cnt) > i);
            check({tag, ".rdy"}, 64'(enq_rdy_o[i]), 64'(rdy));
            fire[i] = enq_vld_i[i] && rdy;
            eptr[i] = (m_tail + nf) % D;
            if (fire[i]) begin
                check({tag, ".eptr"}, 64'(enq_ptr_o[i*PW +: PW]), 64'(eptr[i]));
                nf++;
            end
        end
        for (int j = 0; j < D; j++) begin
`ifdef FIAO_AGE_SEL_EN
            slot = (m_head + j) % D;
`else
            slot = j;
`endif
            if (sel_req_i[slot] && m_vld[slot]) cand.push_back(slot);
        end
        for (int k = 0; k < SW; k++) begin
            gv[k]   = (k < cand.size());
            gptr[k] = gv[k] ? cand[k] : 0;
            em      = gv[k] ? (D'(1) << gptr[k]) : '0;
            check({tag, ".svld"}, 64'(sel_vld_o[k]), 64'(gv[k]));
            if (gv[k]) check({tag, ".sptr"}, 64'(sel_ptr_o[k*PW +: PW]), 64'(gptr[k]));
            check({tag, ".smask"}, 64'(sel_mask_o[k*D +: D]), 64'(em));
        end
        r = 0;
        while (r < DW && r < cnt && !m_vld[(m_head + r) % D]) r++;
        for (int k = 0; k < SW; k++) if (gv[k] && sel_ack_i[k]) m_vld[gptr[k]] = 1'b0;
        for (int i = 0; i < EW; i++) if (fire[i]) m_vld[eptr[i]] = 1'b1;
        m_head = (m_head + r) & 15;
        m_tail = (m_tail + nf) & 15;
        if (flush_i) model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*PW-1:0] exp_pair;

        // Reset
        rstn = 1'b0;
        set_in('0, '0, '0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("rst.empty", 64'(empty_o), 64'(1));
        check("rst.cnt",   64'(cnt_o), 64'(0));
        check("rst.rdy",   64'(enq_rdy_o), 64'(2'b11));
        check("rst.svld",  64'(sel_vld_o), 64'(0));
        check("rst.smask", 64'(sel_mask_o), 64'(0));
        check("rst.eptr",  64'(enq_ptr_o), 64'(6'b001_000));

        // Fill to full
        set_in(2'b11, '0, '0, 1'b0);
        repeat (4) step("fill");
        #1;
        check("full.full", 64'(full_o), 64'(1));
        check("full.cnt",  64'(cnt_o), 64'(8));
        check("full.rdy",  64'(enq_rdy_o), 64'(0));
        step("full.hold");

        // Flush with enqueue and ack pending
        set_in(2'b11, 8'hFF, 2'b11, 1'b1);
        #1;
        check("flush.rdy", 64'(enq_rdy_o), 64'(0));
        step("flush");
        set_in('0, '0, '0, 1'b0);
        #1;
        check("flush.cnt",   64'(cnt_o), 64'(0));
        check("flush.vld",   64'(entry_vld_o), 64'(0));
        check("flush.empty", 64'(empty_o), 64'(1));

        // Sparse lane 1 on an empty queue gets slot 0
        set_in(2'b10, '0, '0, 1'b0);
        #1;
        check("sparse.eptr1", 64'(enq_ptr_o[PW +: PW]), 64'(0));
        step("sparse");

        // Holes
        set_in('0, '0, '0, 1'b1);
        step("holes.flush");
        set_in(2'b11, '0, '0, 1'b0);
        repeat (2) step("holes.fill");
        set_in('0, 8'h0A, 2'b11, 1'b0);
        #1;
        check("holes.sptr", 64'(sel_ptr_o), 64'({3'd3, 3'd1}));
        step("holes.ack13");
        set_in('0, '0, '0, 1'b0);
        #1;
        check("holes.vld", 64'(entry_vld_o), 64'(8'h05));
        check("holes.cnt4", 64'(cnt_o), 64'(4));
        step("holes.idle");
        set_in('0, 8'h01, 2'b01, 1'b0);
        step("holes.ack0");
        set_in('0, '0, '0, 1'b0);
        step("holes.retire");
        #1;
        check("holes.cnt2", 64'(cnt_o), 64'(2));

        // Retire limit: four holes at head retire two per edge
        set_in('0, '0, '0, 1'b1);
        step("lim.flush");
        set_in(2'b11, '0, '0, 1'b0);
        repeat (2) step("lim.fill");
        set_in('0, 8'h06, 2'b11, 1'b0);
        step("lim.ack12");
        set_in('0, 8'h08, 2'b01, 1'b0);
        step("lim.ack3");
        set_in('0, 8'h01, 2'b01, 1'b0);
        step("lim.ack0");
        set_in('0, '0, '0, 1'b0);
        #1;
        check("lim.cnt4", 64'(cnt_o), 64'(4));
        step("lim.r1");
        #1;
        check("lim.cnt2", 64'(cnt_o), 64'(2));
        step("lim.r2");
        #1;
        check("lim.cnt0", 64'(cnt_o), 64'(0));

        // Wrap and age: head at 6, slots 6,7,0,1 valid
        set_in(2'b11, '0, '0, 1'b0);
        repeat (2) step("wrap.fill");
        set_in('0, 8'h30, 2'b11, 1'b0);
        step("wrap.ack45");
        set_in('0, '0, '0, 1'b0);
        step("wrap.retire");
        set_in(2'b11, '0, '0, 1'b0);
        step("wrap.enq01");
        set_in('0, 8'hFF, '0, 1'b0);
        #1;
`ifdef FIAO_AGE_SEL_EN
        exp_pair = {3'd7, 3'd6};
`else
        exp_pair = {3'd1, 3'd0};
`endif
        check("wrap.sptr", 64'(sel_ptr_o), 64'(exp_pair));
        step("wrap.sel");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_in(2'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 31) == 0));
            step("rnd");
        end

        // Asynchronous reset mid-operation
        set_in(2'b11, 8'hFF, 2'b11, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("arst.cnt",  64'(cnt_o), 64'(0));
        check("arst.vld",  64'(entry_vld_o), 64'(0));
        check("arst.svld", 64'(sel_vld_o), 64'(0));
        model_reset();
        set_in('0, '0, '0, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        set_in(2'b11, 8'hFF, 2'b01, 1'b0);
        repeat (4) step("post_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
